// File: rtl/z_run_length_encoder.sv
// Run-length encoder for the Z stream: emits {bit,len} records through a small FIFO.
// Latency: a record is visible one cycle after the sample/flush that closes its run.
// Backpressure: rec_ready stalls the FIFO head; pushes into a full FIFO are dropped and flag overflow.
module z_run_length_encoder #(
    parameter int LEN_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Z,
    input  logic             z_valid,
    input  logic             flush,
    input  logic             rec_ready,
    output logic             rec_valid,
    output logic             rec_bit,
    output logic [LEN_W-1:0] rec_len,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] MAXLEN = '1;
    localparam logic [LEN_W-1:0] ONE    = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH2} state_t;

    typedef struct packed {
        logic             val;
        logic [LEN_W-1:0] len;
    } rec_t;

    state_t           state;
    logic             cur_bit;
    logic [LEN_W-1:0] cur_len;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    rec_t             last_rec;

    logic push_vld;
    rec_t push_rec;
    logic fifo_full;
    logic pop;
    logic push_ok;
    logic run_break;

    // A run closes on a bit change or when it would exceed MAXLEN.
    assign run_break = z_valid && ((Z != cur_bit) || (cur_len == MAXLEN));

    always_comb begin
        push_vld = 1'b0;
        push_rec = '0;
        case (state)
            IDLE: begin
                if (z_valid && flush) begin
                    push_vld = 1'b1;
                    push_rec = '{val: Z, len: ONE};
                end
            end
            RUN: begin
                if (run_break || (flush && !z_valid)) begin
                    push_vld = 1'b1;
                    push_rec = '{val: cur_bit, len: cur_len};
                end else if (flush) begin
                    push_vld = 1'b1;
                    push_rec = '{val: cur_bit, len: cur_len + ONE};
                end
            end
            FLUSH2: begin
                push_vld = 1'b1;
                push_rec = '{val: cur_bit, len: cur_len};
            end
            default: begin
                push_vld = 1'b0;
                push_rec = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cur_bit <= 1'b0;
            cur_len <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (z_valid) begin
                        cur_bit <= Z;
                        cur_len <= flush ? '0 : ONE;
                        state   <= flush ? IDLE : RUN;
                    end
                end
                RUN: begin
                    if (run_break) begin
                        // The new 1-sample run must be flushed on the next cycle.
                        cur_bit <= Z;
                        cur_len <= ONE;
                        state   <= flush ? FLUSH2 : RUN;
                    end else if (z_valid) begin
                        cur_len <= flush ? '0 : cur_len + ONE;
                        state   <= flush ? IDLE : RUN;
                    end else if (flush) begin
                        cur_len <= '0;
                        state   <= IDLE;
                    end
                end
                FLUSH2: begin
                    if (z_valid) begin
                        cur_bit <= Z;
                        cur_len <= ONE;
                        state   <= RUN;
                    end else begin
                        cur_len <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cur_len <= '0;
                end
            endcase
        end
    end

    assign rec_valid = (fifo_count != '0);
    assign fifo_full = (fifo_count == CNT_W'(DEPTH));
    assign pop       = rec_valid && rec_ready;
    assign push_ok   = push_vld && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            last_rec   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                last_rec <= mem[rd_ptr];
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push_ok && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (push_vld && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // With the FIFO empty the outputs keep showing the last record consumed.
    assign rec_bit = rec_valid ? mem[rd_ptr].val : last_rec.val;
    assign rec_len = rec_valid ? mem[rd_ptr].len : last_rec.len;

endmodule

// File: tb/tb_z_run_length_encoder.sv
// Directed bench for z_run_length_encoder: each task drives one scenario and checks inline.
module tb_z_run_length_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Z = 1'b0;
    logic       z_valid = 1'b0;
    logic       flush = 1'b0;
    logic       rec_ready = 1'b0;
    logic       rec_valid;
    logic       rec_bit;
    logic [7:0] rec_len;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    z_run_length_encoder #(.LEN_W(8), .DEPTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .Z          (Z),
        .z_valid    (z_valid),
        .flush      (flush),
        .rec_ready  (rec_ready),
        .rec_valid  (rec_valid),
        .rec_bit    (rec_bit),
        .rec_len    (rec_len),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; Z = 1'b0; z_valid = 1'b0; flush = 1'b0; rec_ready = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic sample(input logic b);
        Z = b; z_valid = 1'b1;
        cycle();
        z_valid = 1'b0;
    endtask

    task automatic test_reset();
        rec_ready = 1'b1; sample(1'b1); sample(1'b0);
        do_reset();
        checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", rec_valid); end
        checks++; if (rec_bit !== 1'b0) begin failures++; $display("FAIL reset_bit got=%b want=0", rec_bit); end
        checks++; if (rec_len !== 8'd0) begin failures++; $display("FAIL reset_len got=%0d want=0", rec_len); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    endtask

    task automatic test_basic();
        logic [3:0] pat;
        pat = 4'b1110;
        do_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(pat[3-i]);
            if (i < 3) begin
                checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid i=%0d got=%b want=0", i, rec_valid); end
            end
        end
        checks++; if (rec_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", rec_valid); end
        checks++; if (rec_bit !== 1'b1 || rec_len !== 8'd3) begin failures++; $display("FAIL basic_rec got={%b,%0d} want={1,3}", rec_bit, rec_len); end
        cycle();
        checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b want=0", rec_valid); end
        checks++; if (rec_bit !== 1'b1 || rec_len !== 8'd3) begin failures++; $display("FAIL basic_hold got={%b,%0d} want={1,3}", rec_bit, rec_len); end
    endtask

    task automatic test_saturation();
        logic       bits [4];
        logic [7:0] lens [4];
        int         n;
        int         first_at;
        n = 0; first_at = -1;
        do_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 302; i++) begin
            if (i < 300) begin Z = 1'b0; z_valid = 1'b1; flush = 1'b0; end
            else if (i == 300) begin z_valid = 1'b0; flush = 1'b1; end
            else begin z_valid = 1'b0; flush = 1'b0; end
            cycle();
            if (rec_valid === 1'b1) begin
                if (n == 0) first_at = i;
                if (n < 4) begin bits[n] = rec_bit; lens[n] = rec_len; end
                n++;
            end
        end
        flush = 1'b0;
        checks++; if (n != 2) begin failures++; $display("FAIL sat_count got=%0d want=2", n); end
        checks++; if (first_at != 255) begin failures++; $display("FAIL sat_first_time got=%0d want=255", first_at); end
        if (n >= 2) begin
            checks++; if (bits[0] !== 1'b0 || lens[0] !== 8'd255) begin failures++; $display("FAIL sat_rec0 got={%b,%0d} want={0,255}", bits[0], lens[0]); end
            checks++; if (bits[1] !== 1'b0 || lens[1] !== 8'd45) begin failures++; $display("FAIL sat_rec1 got={%b,%0d} want={0,45}", bits[1], lens[1]); end
        end
    endtask

    task automatic test_overflow();
        logic [3:0] exp;
        exp = 4'b1010;
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) sample(i[0] ? 1'b0 : 1'b1);
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full got=cnt%0d/ovf%b want=cnt4/ovf0", fifo_count, overflow); end
        sample(1'b0);
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_drop got=cnt%0d/ovf%b want=cnt4/ovf1", fifo_count, overflow); end
        rec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (rec_valid !== 1'b1 || rec_bit !== exp[3-k] || rec_len !== 8'd1) begin failures++; $display("FAIL ovf_drain%0d got={%b,%b,%0d} want={1,%b,1}", k, rec_valid, rec_bit, rec_len, exp[3-k]); end
            cycle();
        end
        checks++; if (rec_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_empty got=v%b/cnt%0d/ovf%b want=v0/cnt0/ovf1", rec_valid, fifo_count, overflow); end
        rec_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [3:0] exp;
        exp = 4'b0101;
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) sample(i[0] ? 1'b0 : 1'b1);
        rec_ready = 1'b1;
        sample(1'b0);
        rec_ready = 1'b0;
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL fpp_state got=cnt%0d/ovf%b want=cnt4/ovf0", fifo_count, overflow); end
        rec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (rec_valid !== 1'b1 || rec_bit !== exp[3-k]) begin failures++; $display("FAIL fpp_drain%0d got={%b,%b} want={1,%b}", k, rec_valid, rec_bit, exp[3-k]); end
            cycle();
        end
        rec_ready = 1'b0;
    endtask

    task automatic test_gap();
        int stray;
        stray = 0;
        do_reset();
        rec_ready = 1'b1;
        sample(1'b1); sample(1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (rec_valid !== 1'b0) stray++;
        end
        sample(1'b1);
        checks++; if (stray != 0 || rec_valid !== 1'b0) begin failures++; $display("FAIL gap_stray got=%0d want=0", stray); end
        sample(1'b0);
        checks++; if (rec_valid !== 1'b1 || rec_bit !== 1'b1 || rec_len !== 8'd3) begin failures++; $display("FAIL gap_rec got={%b,%b,%0d} want={1,1,3}", rec_valid, rec_bit, rec_len); end
    endtask

    task automatic test_flush_change();
        do_reset();
        rec_ready = 1'b0;
        sample(1'b1); sample(1'b1);
        Z = 1'b0; z_valid = 1'b1; flush = 1'b1;
        cycle();
        z_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL fc_first got=%0d want=1", fifo_count); end
        cycle();
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL fc_second got=%0d want=2", fifo_count); end
        cycle();
        flush = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL fc_idle_flush got=%0d want=2", fifo_count); end
        rec_ready = 1'b1;
        checks++; if (rec_bit !== 1'b1 || rec_len !== 8'd2) begin failures++; $display("FAIL fc_rec0 got={%b,%0d} want={1,2}", rec_bit, rec_len); end
        cycle();
        checks++; if (rec_bit !== 1'b0 || rec_len !== 8'd1) begin failures++; $display("FAIL fc_rec1 got={%b,%0d} want={0,1}", rec_bit, rec_len); end
        cycle();
        rec_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 6; i++) sample(i[0] ? 1'b0 : 1'b1);
        rec_ready = 1'b1;
        cycle(); cycle();
        rec_ready = 1'b0;
        sample(1'b0);
        checks++; if (fifo_count !== 3'd2 || overflow !== 1'b1) begin failures++; $display("FAIL rm_pre got=cnt%0d/ovf%b want=cnt2/ovf1", fifo_count, overflow); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if (rec_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin failures++; $display("FAIL rm_post got=v%b/cnt%0d/ovf%b want=v0/cnt0/ovf0", rec_valid, fifo_count, overflow); end
        checks++; if (rec_len !== 8'd0) begin failures++; $display("FAIL rm_len got=%0d want=0", rec_len); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        checks++; if (rec_valid !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL rm_flush got=v%b/cnt%0d want=v0/cnt0", rec_valid, fifo_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_full_push_pop();
        test_gap();
        test_flush_change();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
